// File: rtl/bht_update_scheduler.sv
// BHT update scheduler: sweeps a clear over every table entry after reset, then
// serialises up to two resolved-branch updates per cycle onto the single update port.
module bht_update_scheduler #(
    parameter int IDX_W = 6,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   upd0_valid,
    input  logic [IDX_W-1:0]       upd0_pc,
    input  logic                   upd0_taken,
    input  logic                   upd1_valid,
    input  logic [IDX_W-1:0]       upd1_pc,
    input  logic                   upd1_taken,
    output logic                   upd_stall,
    output logic                   bht_upd,
    output logic [IDX_W-1:0]       bht_pc,
    output logic                   bht_taken,
    output logic                   bht_clr,
    output logic                   init_busy,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   ovf
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = {IDX_W{1'b1}};

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic [IDX_W-1:0] pc;
        logic             taken;
    } entry_t;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             bht_upd_q, bht_upd_d;
    logic [IDX_W-1:0] bht_pc_q, bht_pc_d;
    logic             bht_taken_q, bht_taken_d;
    logic             bht_clr_q, bht_clr_d;
    logic             init_busy_q, init_busy_d;
    logic             upd_stall_q, upd_stall_d;
    entry_t           mem_q [DEPTH];

    logic [CNT_W-1:0] free_s;
    logic             push0_s, push1_s, drop_s, pop_s;
    logic [PTR_W-1:0] wa0_s, wa1_s;
    entry_t           head_s;

    assign free_s = DEPTH_C - count_q;
    assign pop_s  = (state_q == ST_RUN) && (count_q != {CNT_W{1'b0}});
    assign head_s = mem_q[rd_ptr_q];
    assign wa0_s  = wr_ptr_q;
    assign wa1_s  = wr_ptr_q + PTR_W'(push0_s);

    // Admission: slot 0 always claims the first free slot; slot 1 is the first to be dropped.
    always_comb begin
        push0_s = 1'b0;
        push1_s = 1'b0;
        drop_s  = 1'b0;
        if (state_q == ST_RUN) begin
            if (upd0_valid && upd1_valid) begin
                if (free_s >= CNT_W'(2)) begin
                    push0_s = 1'b1;
                    push1_s = 1'b1;
                end else if (free_s == CNT_W'(1)) begin
                    push0_s = 1'b1;
                    drop_s  = 1'b1;
                end else begin
                    drop_s  = 1'b1;
                end
            end else if (upd0_valid || upd1_valid) begin
                if (free_s != {CNT_W{1'b0}}) begin
                    push0_s = upd0_valid;
                    push1_s = upd1_valid;
                end else begin
                    drop_s  = 1'b1;
                end
            end else begin
                drop_s = 1'b0;
            end
        end else begin
            drop_s = 1'b0;
        end
    end

    // Next-state for the sweep/run FSM, FIFO bookkeeping and the registered outputs.
    always_comb begin
        state_d     = state_q;
        clr_idx_d   = clr_idx_q;
        bht_upd_d   = 1'b0;
        bht_pc_d    = bht_pc_q;
        bht_taken_d = bht_taken_q;
        bht_clr_d   = 1'b0;
        init_busy_d = init_busy_q;
        ovf_d       = ovf_q | drop_s;
        wr_ptr_d    = wr_ptr_q + PTR_W'(push0_s) + PTR_W'(push1_s);
        rd_ptr_d    = rd_ptr_q + PTR_W'(pop_s);
        count_d     = count_q + CNT_W'(push0_s) + CNT_W'(push1_s) - CNT_W'(pop_s);
        case (state_q)
            ST_INIT: begin
                bht_clr_d   = 1'b1;
                bht_pc_d    = clr_idx_q;
                bht_taken_d = 1'b0;
                init_busy_d = 1'b1;
                clr_idx_d   = clr_idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
                if (clr_idx_q == LAST_IDX) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_RUN: begin
                init_busy_d = 1'b0;
                bht_upd_d   = pop_s;
                if (pop_s) begin
                    bht_pc_d    = head_s.pc;
                    bht_taken_d = head_s.taken;
                end else begin
                    bht_pc_d    = bht_pc_q;
                    bht_taken_d = bht_taken_q;
                end
            end
            default: begin
                state_d     = ST_INIT;
                clr_idx_d   = {IDX_W{1'b0}};
                init_busy_d = 1'b1;
            end
        endcase
        // Registered form of the stall: same value as deriving it from the live count.
        upd_stall_d = (state_d != ST_RUN) || ((DEPTH_C - count_d) < CNT_W'(2));
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_INIT;
            clr_idx_q   <= {IDX_W{1'b0}};
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            count_q     <= {CNT_W{1'b0}};
            ovf_q       <= 1'b0;
            bht_upd_q   <= 1'b0;
            bht_pc_q    <= {IDX_W{1'b0}};
            bht_taken_q <= 1'b0;
            bht_clr_q   <= 1'b0;
            init_busy_q <= 1'b1;
            upd_stall_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            clr_idx_q   <= clr_idx_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            bht_upd_q   <= bht_upd_d;
            bht_pc_q    <= bht_pc_d;
            bht_taken_q <= bht_taken_d;
            bht_clr_q   <= bht_clr_d;
            init_busy_q <= init_busy_d;
            upd_stall_q <= upd_stall_d;
        end
    end

    // FIFO storage holds data only; occupancy lives in count_q, so reset need not clear it.
    always_ff @(posedge clk) begin
        if (push0_s) begin
            mem_q[wa0_s] <= entry_t'({upd0_pc, upd0_taken});
        end
        if (push1_s) begin
            mem_q[wa1_s] <= entry_t'({upd1_pc, upd1_taken});
        end
    end

    assign upd_stall  = upd_stall_q;
    assign bht_upd    = bht_upd_q;
    assign bht_pc     = bht_pc_q;
    assign bht_taken  = bht_taken_q;
    assign bht_clr    = bht_clr_q;
    assign init_busy  = init_busy_q;
    assign fifo_count = count_q;
    assign ovf        = ovf_q;

endmodule

// File: doc/bht_update_scheduler.md
Name: bht_update_scheduler

Overview:
Sequences all writes into the 64-entry 2-bit branch history table of the dual-issue core.
- After reset it walks every table index once, issuing clear commands.
- It then accepts up to two resolved-branch updates per cycle, one from issue slot 0 (older) and one from slot 1 (younger). These are buffered in program order.
- The predictor's single update port is driven with one update per cycle.
- It back-pressures the resolve stage when buffer space runs short.

Parameters:
IDX_W, 6, table index width; the table has 2^IDX_W entries.
DEPTH, 4, update FIFO depth in entries; a power of 2, at least 2.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset (0 = in reset).
upd0_valid  input  1  slot-0 branch resolved this cycle.
upd0_pc  input  IDX_W  slot-0 table index.
upd0_taken  input  1  slot-0 actual outcome.
upd1_valid  input  1  slot-1 branch resolved this cycle.
upd1_pc  input  IDX_W  slot-1 table index.
upd1_taken  input  1  slot-1 actual outcome.
upd_stall  output  1  resolve stage must hold; new updates are not guaranteed to be accepted.
bht_upd  output  1  counter-update strobe to the predictor (its branch input).
bht_pc  output  IDX_W  index for an update or a clear.
bht_taken  output  1  outcome for the update.
bht_clr  output  1  force the entry at bht_pc to 2'b00.
init_busy  output  1  clear sweep in progress.
fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy.
ovf  output  1  sticky flag: an update was dropped.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=INIT, clr_idx=0, FIFO emptied, ovf=0.
  - bht_upd=0, bht_clr=0, bht_pc=0, bht_taken=0.
  - init_busy=1, upd_stall=1.
- All bht_* outputs are registered.
- INIT state:
  - Each clock edge registers bht_clr=1, bht_pc=clr_idx, bht_upd=0, then increments clr_idx.
  - The edge that registers clr_idx=2^IDX_W-1 moves the state to RUN.
  - The next edge clears bht_clr and init_busy.
  - Result: exactly 2^IDX_W consecutive clear cycles (64 by default), indices 0..63 ascending.
  - In INIT, upd*_valid is ignored and does not set ovf.
- RUN state:
  - upd_stall = (DEPTH - fifo_count) < 2. It is derived from registered count only; it does not look ahead for same-cycle pops.
  - Push: free slots = DEPTH - fifo_count, without credit for a same-edge pop.
    - Slot 0 is enqueued first if valid, then slot 1 if valid.
    - Order is always slot 0 before slot 1.
    - Only upd1_valid set: slot 1 is enqueued alone.
  - Overflow (more valid inputs than free slots):
    - The excess is dropped, slot 1 first.
    - ovf is set and stays 1 until reset.
    - The FIFO is never corrupted.
  - Pop:
    - If fifo_count>0 before the edge, the head is popped.
    - That edge registers bht_upd=1 with bht_pc and bht_taken from the head.
    - Otherwise bht_upd=0. bht_clr=0 throughout RUN.
  - Latency: an entry pushed at edge N into an empty FIFO is presented after edge N+1, i.e. bht_upd is high in the cycle following N+1. There is no bypass.
  - Throughput: 1 update per cycle. Simultaneous push and pop are legal: count_next = count + pushes - pop.
- Same-index updates are not merged. Two updates to one index are applied as two sequential writes in program order.
- Pointers wrap modulo DEPTH; fifo_count ranges 0..DEPTH.
- Reset asserted mid-sweep or mid-drain:
  - Outputs go to reset values immediately.
  - Pending FIFO entries are discarded.
  - On release, the sweep restarts from index 0.

Test Plan:
1. Release reset, no updates -> bht_clr=1 for exactly 64 cycles with bht_pc 0,1,…,63; bht_upd=0 throughout. Then init_busy=0, upd_stall=0, fifo_count=0.
2. After init, upd0_valid=1, pc=5, taken=1 for one cycle (edge N) -> bht_upd=1, bht_pc=5, bht_taken=1 for exactly one cycle after edge N+1, then bht_upd=0.
3. Same cycle: upd0 (pc=3, taken=0) and upd1 (pc=3, taken=1) -> two consecutive bht_upd cycles: (3,0) then (3,1). ovf=0.
4. DEPTH=4: dual updates on 2 consecutive cycles, indices 10,11,12,13 -> fifo_count peaks at 3; upd_stall=1 while count ≥3. Writes are 10,11,12,13 in order at 1 per cycle with no gaps after the first. ovf=0.
5. Ignore stall: fifo_count=3, present dual (pc=20, pc=21) -> 20 is accepted, 21 is dropped, and ovf=1 stays set through subsequent idle cycles.
6. Assert reset with fifo_count=2 mid-drain -> bht_upd=0 and fifo_count=0 immediately, with no further writes of the queued entries. After release, the clear sweep restarts at bht_pc=0.
